// File: rtl/mxalu_seq.sv
// Multi-byte sequencer for an external 8-bit 74181-style ALU slice: one byte per cycle, LSB first.
// Optional MXALU_SEQ_B2B_EN lets a new request be accepted in the same cycle the response is taken.
module mxalu_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic [3:0]            req_s,
  input  logic                  req_m,
  input  logic                  req_cn_n,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [3:0]            alu_s,
  output logic                  alu_m,
  output logic                  alu_cn_n,
  input  logic [7:0]            alu_f,
  input  logic                  alu_cn8_n,
  input  logic                  alu_a_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [8*NBYTES-1:0]   resp_f,
  output logic                  resp_cout_n,
  output logic                  resp_eq
);

  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NBYTES-1:0][7:0] op_a;
  logic [NBYTES-1:0][7:0] op_b;
  logic [NBYTES-1:0][7:0] res_f;
  logic [3:0]             op_s;
  logic                   op_m;
  logic                   carry_n;
  logic                   eq;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          sel;
  logic                   ready_st;
  logic                   accept;
  logic                   last;

  assign last = (idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    ready_st  = 1'b0;
    case (state)
      IDLE: begin
        ready_st = 1'b1;
        if (req_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
`ifdef MXALU_SEQ_B2B_EN
        ready_st = resp_ready;
        if (resp_ready) state_nxt = req_valid ? RUN : IDLE;
`else
        if (resp_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces ready low combinationally so nothing is seen as accepted during reset.
  assign req_ready = ready_st & ~rst;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_s    <= '0;
      op_m    <= 1'b0;
      res_f   <= '0;
      carry_n <= 1'b1;
      eq      <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      op_a    <= req_a;
      op_b    <= req_b;
      op_s    <= req_s;
      op_m    <= req_m;
      carry_n <= req_cn_n;
      eq      <= 1'b1;
      idx     <= '0;
    end else if (state == RUN) begin
      res_f[idx] <= alu_f;
      carry_n    <= alu_cn8_n;
      eq         <= eq & alu_a_b;
      if (!last) idx <= idx + 1'b1;
    end
  end

  // Outside RUN the ALU sees byte 0 so its inputs stay deterministic.
  assign sel      = (state == RUN) ? idx : '0;
  assign alu_a    = op_a[sel];
  assign alu_b    = op_b[sel];
  assign alu_s    = op_s;
  assign alu_m    = op_m;
  assign alu_cn_n = carry_n;

  assign resp_valid  = (state == DONE);
  assign resp_f      = res_f;
  assign resp_cout_n = carry_n;
  assign resp_eq     = eq;

endmodule

// File: tb/tb_mxalu_seq.sv
// Directed bench for mxalu_seq with a behavioural 74181-style ALU model on the ALU port.
module tb_mxalu_seq;

  localparam int NB = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [8*NB-1:0]   req_a, req_b;
  logic [3:0]        req_s;
  logic              req_m, req_cn_n;
  logic [7:0]        alu_a, alu_b, alu_f;
  logic [3:0]        alu_s;
  logic              alu_m, alu_cn_n, alu_cn8_n, alu_a_b;
  logic              resp_valid, resp_ready;
  logic [8*NB-1:0]   resp_f;
  logic              resp_cout_n, resp_eq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mxalu_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cn_n(req_cn_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn_n(alu_cn_n),
    .alu_f(alu_f), .alu_cn8_n(alu_cn8_n), .alu_a_b(alu_a_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_f(resp_f), .resp_cout_n(resp_cout_n), .resp_eq(resp_eq)
  );

  // ALU model, active-high data: 1001 arith = A+B+c, 0110 arith = A-B-1+c, 0110 logic = XOR.
  logic [8:0] sum;
  always_comb begin
    sum = 9'd0;
    if (alu_m) begin
      if (alu_s == 4'b0110) sum = {1'b0, alu_a ^ alu_b};
      else                  sum = {1'b0, ~alu_a};
      alu_f     = sum[7:0];
      alu_cn8_n = 1'b1;
    end else begin
      case (alu_s)
        4'b1001: sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, ~alu_cn_n};
        4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, ~alu_cn_n};
        default: sum = {1'b0, alu_a} + {8'd0, ~alu_cn_n};
      endcase
      alu_f     = sum[7:0];
      alu_cn8_n = ~sum[8];
    end
    alu_a_b = (alu_f == 8'hFF);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check latency and result, optionally hold off resp_ready.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cn,
                       input logic [15:0] ef, input logic ecout, input logic chk_cout,
                       input logic eeq, input logic chk_eq, input int hold);
    int cyc;
    req_a = a; req_b = b; req_s = s; req_m = m; req_cn_n = cn;
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin step(); cyc++; end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    req_a = '0; req_b = '0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin step(); cyc++; end
    chk({tag, "_latency"}, 64'(cyc), 64'd2);
    chk({tag, "_f"}, 64'(resp_f), 64'(ef));
    if (chk_cout) chk({tag, "_cout_n"}, 64'(resp_cout_n), 64'(ecout));
    if (chk_eq)   chk({tag, "_eq"}, 64'(resp_eq), 64'(eeq));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_hold_f"}, 64'(resp_f), 64'(ef));
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_valid_fall"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    int acc[$];
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cn_n = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_f", 64'(resp_f), 64'd0);
    chk("rst_cout_n", 64'(resp_cout_n), 64'd1);
    chk("rst_eq", 64'(resp_eq), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_cn_n", 64'(alu_cn_n), 64'd1);
    rst = 1'b0;
    step();
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    do_op("add_ripple", 16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h1300, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    do_op("add_ovf",    16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    do_op("xor",        16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hAA55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op("cmp_eq",     16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    do_op("cmp_ne",     16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    do_op("backpress",  16'h0102, 16'h0304, 4'b1001, 1'b0, 1'b1, 16'h0406, 1'b1, 1'b1, 1'b0, 1'b0, 5);

    // Reset during RUN.
    req_a = 16'h00FF; req_b = 16'h0001; req_s = 4'b1001; req_m = 1'b0; req_cn_n = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #2;
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_resp_f", 64'(resp_f), 64'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_valid", 64'(resp_valid), 64'd0);
    end
    chk("midrst_idle", 64'(req_ready), 64'd1);

    // Back-to-back with valid held high and consumer always ready.
    req_a = 16'h0010; req_b = 16'h0020; req_s = 4'b1001; req_m = 1'b0; req_cn_n = 1'b1;
    req_valid = 1'b1; resp_ready = 1'b1;
    for (cyc = 0; cyc < 14; cyc++) begin
      if (req_ready) acc.push_back(cyc);
      step();
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 64'(acc.size() >= 3), 64'd1);
    if (acc.size() >= 3) begin
`ifdef MXALU_SEQ_B2B_EN
      chk("b2b_spacing0", 64'(acc[1] - acc[0]), 64'd3);
      chk("b2b_spacing1", 64'(acc[2] - acc[1]), 64'd3);
`else
      chk("b2b_spacing0", 64'(acc[1] - acc[0]), 64'd4);
      chk("b2b_spacing1", 64'(acc[2] - acc[1]), 64'd4);
`endif
    end
    chk("b2b_result", 64'(resp_f), 64'h0030);
    resp_ready = 1'b0;
    step(); step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mxalu_seq.md
# mxalu_seq

Multi-byte operation sequencer for the 8-bit 74181-style ALU slice (`mxalu_181`). It accepts one NBYTES×8-bit operation per valid/ready handshake and drives the shared 8-bit ALU one byte per cycle, least-significant byte first. The active-low ripple carry is registered between passes, and the A=B indication is accumulated across all passes. The result is presented on a valid/ready response port. The block sits between the MX control unit and a single `mxalu_181` instance; the ALU itself is instantiated outside this block.

## Interface
- NBYTES, default 2: operand width in bytes; legal range 2..8.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  operation request valid.
- req_ready  out  1  block can accept a request.
- req_a, req_b  in  8*NBYTES  operands.
- req_s  in  4  ALU function select.
- req_m  in  1  mode: 1 = logic, 0 = arithmetic.
- req_cn_n  in  1  active-low carry-in to byte 0.
- alu_a, alu_b  out  8  operand byte to the ALU.
- alu_s  out  4  function select to the ALU.
- alu_m  out  1  mode to the ALU.
- alu_cn_n  out  1  carry-in to the ALU.
- alu_f  in  8  ALU result (combinational).
- alu_cn8_n  in  1  ALU carry-out, active-low.
- alu_a_b  in  1  ALU A=B output.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_f  out  8*NBYTES  result.
- resp_cout_n  out  1  final carry-out, active-low.
- resp_eq  out  1  AND of alu_a_b over all passes.

## Operation
- States:
  - IDLE: `req_ready` = 1. On `req_valid`, latch a, b, s, m into op registers; `carry_n` ← `req_cn_n`; `idx` ← 0; `eq` ← 1; go to RUN.
  - RUN: each cycle, drive the ALU and capture its outputs:
    - Drive: `alu_a` = a[idx], `alu_b` = b[idx], `alu_s`/`alu_m` from the op registers, `alu_cn_n` = `carry_n`.
    - Capture at the clock edge: `f[idx]` ← `alu_f`; `carry_n` ← `alu_cn8_n`; `eq` ← `eq` & `alu_a_b`; `idx` ← `idx` + 1.
    - When `idx` == NBYTES-1, go to DONE.
  - DONE: `resp_valid` = 1. `resp_f`, `resp_cout_n` (= `carry_n`) and `resp_eq` are held stable. On `resp_ready`, go to IDLE.
- `req_ready` is 0 in RUN, in DONE (unless the macro in Configuration is set), and while `rst` is high.
- `req_*` inputs are ignored when no handshake occurs.
- In logic mode, carry propagation still runs. `resp_cout_n` is whatever the ALU reports; the consumer ignores it.
- `idx` is a ceil(log2(NBYTES))-bit counter. It never wraps past NBYTES-1 within an operation and is reset to 0 on each accept.
- Outside RUN, the ALU drive outputs present byte 0 of the op registers with `alu_cn_n` = `carry_n`. Their value is don't-care for function but deterministic.
- Reset values:
  - State = IDLE.
  - All op/result registers = 0; `carry_n` = 1; `eq` = 0.
  - `resp_valid` = 0; `resp_f` = 0; `resp_cout_n` = 1; `resp_eq` = 0.
  - ALU drive: `alu_a`/`alu_b` = 0, `alu_s` = 0, `alu_m` = 0, `alu_cn_n` = 1.
  - `req_ready` = 0 while `rst` is high.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No response is produced.

## Timing
- Accept at edge T (`req_valid` & `req_ready`). Byte k is computed in the cycle after edge T+k.
- `resp_valid` rises after edge T+NBYTES. Latency is NBYTES cycles.
- Response handshake completes at the first edge with `resp_valid` & `resp_ready`. `resp_valid` falls after that edge.
- Without the macro, minimum request spacing is NBYTES+2 cycles.
- `resp_ready` held low keeps the block in DONE indefinitely with outputs stable.
- The ALU path is combinational within a cycle: registered drive → ALU → capture.

## Configuration
- MXALU_SEQ_B2B_EN defined:
  - In DONE, `req_ready` = `resp_ready`.
  - A simultaneous response handshake and `req_valid` accepts the new operation at the same edge and goes directly to RUN.
  - Spacing becomes NBYTES+1 cycles.
- MXALU_SEQ_B2B_EN undefined: `req_ready` is asserted only in IDLE.

## Test plan
- Add carry ripple: NBYTES=2, a=0x12FF, b=0x0001, s=1001, m=0, cn_n=1 → `resp_f`=0x1300, `resp_cout_n`=1, `resp_valid` exactly 2 cycles after accept.
- Add overflow: a=0xFFFF, b=0x0001, s=1001, m=0, cn_n=1 → `resp_f`=0x0000, `resp_cout_n`=0.
- Logic XOR: a=0xA5A5, b=0x0FF0, s=0110, m=1 → `resp_f`=0xAA55.
- Compare: a=b=0x1234, s=0110, m=0, cn_n=1 → `resp_f`=0xFFFF, `resp_eq`=1. With b=0x1235 → `resp_eq`=0.
- Backpressure/reset:
  - `resp_ready`=0 for 5 cycles → `resp_*` stable, `req_ready`=0.
  - `rst` pulse during RUN → `resp_valid` stays 0, `resp_f`=0, block returns to IDLE.
- Back-to-back: `req_valid` held high, `resp_ready`=1 → with MXALU_SEQ_B2B_EN, accepts every 3 cycles. Without it, every 4 cycles.
